// File: rtl/sram_port_arbiter_if.sv
// Pipeline-side and bus-side signals of the SRAM port arbiter.
// slave is the arbiter's view; master is the core/memory environment's view.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  inst_en;
  logic [ADDR_W-1:0]     inst_addr;
  logic [DATA_W-1:0]     inst_rdata;
  logic                  i_stall;
  logic                  data_en;
  logic [DATA_W/8-1:0]   data_wen;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic [DATA_W-1:0]     data_rdata;
  logic                  d_stall;
  logic                  ext_stall;
  logic                  flush;
  logic                  bus_req;
  logic                  bus_wr;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_W-1:0]     bus_rdata;

  modport slave (
    input  inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata,
    input  ext_stall, flush, bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_rdata, i_stall, data_rdata, d_stall,
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
  );

  modport master (
    output inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata,
    output ext_stall, flush, bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_rdata, i_stall, data_rdata, d_stall,
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access,
// one transaction outstanding, with pipeline stalls and held read data.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter bit          DATA_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst,
  sram_port_arbiter_if.slave sif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]          r_state, w_state_d;
  logic                r_sel, r_discard, r_inst_done, r_data_done;
  logic                r_bus_req, r_bus_wr;
  logic [DATA_W/8-1:0] r_bus_wstrb;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata, r_inst_rdata, r_data_rdata;

  logic w_inst_pend, w_data_pend, w_advance;
  logic w_resp, w_keep, w_inst_cand, w_data_cand, w_issue, w_pick_data;

  assign w_inst_pend = sif.inst_en & ~r_inst_done;
  assign w_data_pend = sif.data_en & ~r_data_done;
  assign w_advance   = ~w_inst_pend & ~w_data_pend & ~sif.ext_stall;

  assign w_resp = (r_state == S_WAIT) & sif.bus_data_ok;
  assign w_keep = w_resp & ~r_discard;

  // The side completing this cycle is no longer a candidate, so the other side
  // can be captured on the response edge and reach the bus one cycle earlier.
  assign w_inst_cand = w_inst_pend & ~(w_keep & ~r_sel);
  assign w_data_cand = w_data_pend & ~(w_keep & r_sel);
  assign w_issue     = ((r_state == S_IDLE) | w_resp) & ~sif.flush &
                       (w_inst_cand | w_data_cand);
  assign w_pick_data = w_data_cand & (DATA_FIRST | ~w_inst_cand);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_IDLE: if (w_issue) w_state_d = S_REQ;
      S_REQ: begin
        if (sif.bus_addr_ok)  w_state_d = S_WAIT;
        else if (sif.flush)   w_state_d = S_IDLE;
      end
      S_WAIT: if (sif.bus_data_ok) w_state_d = w_issue ? S_REQ : S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_discard    <= 1'b0;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_wr     <= 1'b0;
      r_bus_wstrb  <= '0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_state   <= w_state_d;
      r_bus_req <= (w_state_d == S_REQ);

      if (w_issue) begin
        r_sel       <= w_pick_data;
        r_bus_addr  <= w_pick_data ? sif.data_addr : sif.inst_addr;
        r_bus_wr    <= w_pick_data & (|sif.data_wen);
        r_bus_wstrb <= w_pick_data ? sif.data_wen : '0;
        r_bus_wdata <= w_pick_data ? sif.data_wdata : '0;
      end

      // Accepted-then-flushed requests still owe a response, which is swallowed.
      if ((r_state == S_REQ) && sif.bus_addr_ok && sif.flush) begin
        r_discard <= 1'b1;
      end else if (r_state == S_WAIT) begin
        if (sif.bus_data_ok)  r_discard <= 1'b0;
        else if (sif.flush)   r_discard <= 1'b1;
      end

      if (w_keep && !r_sel)              r_inst_rdata <= sif.bus_rdata;
      if (w_keep && r_sel && !r_bus_wr)  r_data_rdata <= sif.bus_rdata;

      if (sif.flush || w_advance) begin
        r_inst_done <= 1'b0;
        r_data_done <= 1'b0;
      end else begin
        if (w_keep && !r_sel) r_inst_done <= 1'b1;
        if (w_keep && r_sel)  r_data_done <= 1'b1;
      end
    end
  end

  assign sif.i_stall    = w_inst_pend;
  assign sif.d_stall    = w_data_pend;
  assign sif.inst_rdata = r_inst_rdata;
  assign sif.data_rdata = r_data_rdata;
  assign sif.bus_req    = r_bus_req;
  assign sif.bus_wr     = r_bus_wr;
  assign sif.bus_wstrb  = r_bus_wstrb;
  assign sif.bus_addr   = r_bus_addr;
  assign sif.bus_wdata  = r_bus_wdata;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a transaction-level model checked every
// cycle, plus literal expectations at the interesting cycles of each scenario.
module tb_sram_port_arbiter;
  localparam bit DATA_FIRST = 1'b1;

  logic clk;
  logic rst;
  logic chk_on;
  int   n_run;
  int   n_fail;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sif ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(DATA_FIRST)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Model: the single outstanding bus transaction as a record, plus per-side
  // completion flags and held read data.
  logic        m_idone, m_ddone, m_ov, m_acc, m_side, m_disc, m_wr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_idone <= 0; m_ddone <= 0; m_ov <= 0; m_acc <= 0; m_side <= 0; m_disc <= 0;
      m_wr <= 0; m_wstrb <= 0; m_addr <= 0; m_wdata <= 0; m_ird <= 0; m_drd <= 0;
    end else begin : upd
      logic        ip, dp, adv, freed, idn, ddn, ov, acc, side, disc, wr;
      logic [3:0]  ws;
      logic [31:0] ad, wd, ird, drd;
      idn = m_idone; ddn = m_ddone; ov = m_ov; acc = m_acc; side = m_side;
      disc = m_disc; wr = m_wr; ws = m_wstrb; ad = m_addr; wd = m_wdata;
      ird = m_ird; drd = m_drd;
      ip  = sif.inst_en & ~idn;
      dp  = sif.data_en & ~ddn;
      adv = ~ip & ~dp & ~sif.ext_stall;
      freed = ~ov;
      if (ov && !acc) begin
        if (sif.bus_addr_ok) begin
          acc = 1;
          if (sif.flush) disc = 1;
        end else if (sif.flush) begin
          ov = 0;
        end
      end else if (ov) begin
        if (sif.bus_data_ok) begin
          if (!disc) begin
            if (side) begin ddn = 1; dp = 0; if (!wr) drd = sif.bus_rdata; end
            else begin idn = 1; ip = 0; ird = sif.bus_rdata; end
          end
          ov = 0; acc = 0; disc = 0; freed = 1;
        end else if (sif.flush) begin
          disc = 1;
        end
      end
      if (freed && !sif.flush && (ip || dp)) begin
        ov = 1; acc = 0;
        side = dp && (DATA_FIRST || !ip);
        ad = side ? sif.data_addr : sif.inst_addr;
        ws = side ? sif.data_wen : 4'b0;
        wr = side && (ws != 0);
        wd = side ? sif.data_wdata : 32'h0;
      end
      if (sif.flush || adv) begin idn = 0; ddn = 0; end
      m_idone <= idn; m_ddone <= ddn; m_ov <= ov; m_acc <= acc; m_side <= side;
      m_disc <= disc; m_wr <= wr; m_wstrb <= ws; m_addr <= ad; m_wdata <= wd;
      m_ird <= ird; m_drd <= drd;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m.i_stall",    sif.i_stall,    sif.inst_en & ~m_idone);
      chk("m.d_stall",    sif.d_stall,    sif.data_en & ~m_ddone);
      chk("m.bus_req",    sif.bus_req,    m_ov & ~m_acc);
      chk("m.bus_addr",   sif.bus_addr,   m_addr);
      chk("m.bus_wr",     sif.bus_wr,     m_wr);
      chk("m.bus_wstrb",  sif.bus_wstrb,  m_wstrb);
      chk("m.bus_wdata",  sif.bus_wdata,  m_wdata);
      chk("m.inst_rdata", sif.inst_rdata, m_ird);
      chk("m.data_rdata", sif.data_rdata, m_drd);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run = 0; n_fail = 0; chk_on = 0; rst = 0;
    sif.inst_en = 0; sif.inst_addr = 0; sif.data_en = 0; sif.data_wen = 0;
    sif.data_addr = 0; sif.data_wdata = 0; sif.ext_stall = 0; sif.flush = 0;
    sif.bus_addr_ok = 0; sif.bus_data_ok = 0; sif.bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1; chk_on = 1;
    #1 chk("rst.bus_req", sif.bus_req, 0);
    chk("rst.bus_addr", sif.bus_addr, 0);
    chk("rst.inst_rdata", sif.inst_rdata, 0);
    chk("rst.data_rdata", sif.data_rdata, 0);

    // Fetch only
    nxt(); sif.inst_en = 1; sif.inst_addr = 32'hBFC00000;
    #1 chk("t1.c0.i_stall", sif.i_stall, 1); chk("t1.c0.bus_req", sif.bus_req, 0);
    nxt(); sif.bus_addr_ok = 1;
    #1 chk("t1.c1.bus_req", sif.bus_req, 1); chk("t1.c1.addr", sif.bus_addr, 32'hBFC00000);
    nxt(); sif.bus_addr_ok = 0; sif.bus_data_ok = 1; sif.bus_rdata = 32'h3C080001;
    #1 chk("t1.c2.i_stall", sif.i_stall, 1); chk("t1.c2.bus_req", sif.bus_req, 0);
    nxt(); sif.bus_data_ok = 0; sif.bus_rdata = 0;
    #1 chk("t1.c3.i_stall", sif.i_stall, 0); chk("t1.c3.rdata", sif.inst_rdata, 32'h3C080001);
    nxt(); sif.inst_en = 0;

    // Both sides at once, data first, held under ext_stall
    nxt(); sif.ext_stall = 1; sif.inst_en = 1; sif.inst_addr = 32'hBFC00004;
    sif.data_en = 1; sif.data_wen = 0; sif.data_addr = 32'h80001000;
    #1 chk("t2.c0.d_stall", sif.d_stall, 1);
    nxt(); sif.bus_addr_ok = 1;
    #1 chk("t2.c1.bus_req", sif.bus_req, 1); chk("t2.c1.addr", sif.bus_addr, 32'h80001000);
    nxt(); sif.bus_addr_ok = 0; sif.bus_data_ok = 1; sif.bus_rdata = 32'h11112222;
    #1 chk("t2.c2.bus_req", sif.bus_req, 0);
    nxt(); sif.bus_data_ok = 0; sif.bus_addr_ok = 1;
    #1 chk("t2.c3.d_stall", sif.d_stall, 0); chk("t2.c3.i_stall", sif.i_stall, 1);
    chk("t2.c3.bus_req", sif.bus_req, 1); chk("t2.c3.addr", sif.bus_addr, 32'hBFC00004);
    chk("t2.c3.drdata", sif.data_rdata, 32'h11112222);
    nxt(); sif.bus_addr_ok = 0; sif.bus_data_ok = 1; sif.bus_rdata = 32'h33334444;
    nxt(); sif.bus_data_ok = 0;
    #1 chk("t2.c5.i_stall", sif.i_stall, 0); chk("t2.c5.irdata", sif.inst_rdata, 32'h33334444);
    nxt(); nxt();
    #1 chk("t2.c7.bus_req", sif.bus_req, 0); chk("t2.c7.d_stall", sif.d_stall, 0);
    chk("t2.c7.irdata", sif.inst_rdata, 32'h33334444);
    chk("t2.c7.drdata", sif.data_rdata, 32'h11112222);
    nxt(); sif.ext_stall = 0;
    nxt(); sif.inst_en = 0; sif.data_en = 0;

    // Partial store
    nxt(); sif.data_en = 1; sif.data_wen = 4'b0011; sif.data_addr = 32'h80000004;
    sif.data_wdata = 32'hAABBCCDD;
    nxt(); sif.bus_addr_ok = 1;
    #1 chk("t3.c1.bus_wr", sif.bus_wr, 1); chk("t3.c1.wstrb", sif.bus_wstrb, 4'b0011);
    chk("t3.c1.wdata", sif.bus_wdata, 32'hAABBCCDD);
    nxt(); sif.bus_addr_ok = 0; sif.bus_data_ok = 1; sif.bus_rdata = 32'h55555555;
    #1 chk("t3.c2.d_stall", sif.d_stall, 1);
    nxt(); sif.bus_data_ok = 0;
    #1 chk("t3.c3.d_stall", sif.d_stall, 0); chk("t3.c3.drdata", sif.data_rdata, 32'h11112222);
    nxt(); sif.data_en = 0; sif.data_wen = 0;

    // Slave stalls acceptance, stray data_ok ignored, flush drops the request
    nxt(); sif.inst_en = 1; sif.inst_addr = 32'hBFC00008;
    nxt(); sif.bus_data_ok = 1; sif.bus_rdata = 32'h99999999;
    #1 chk("t4.c1.bus_req", sif.bus_req, 1);
    nxt(); sif.bus_data_ok = 0;
    #1 chk("t4.c2.bus_req", sif.bus_req, 1); chk("t4.c2.addr", sif.bus_addr, 32'hBFC00008);
    nxt(); sif.flush = 1;
    #1 chk("t4.c3.bus_req", sif.bus_req, 1);
    nxt(); sif.flush = 0; sif.inst_en = 0;
    #1 chk("t4.c4.bus_req", sif.bus_req, 0); chk("t4.c4.irdata", sif.inst_rdata, 32'h33334444);
    nxt();
    #1 chk("t4.c5.bus_req", sif.bus_req, 0);

    // Flush while waiting discards the response; the next fetch is normal
    nxt(); sif.inst_en = 1; sif.inst_addr = 32'hBFC0000C;
    nxt(); sif.bus_addr_ok = 1;
    nxt(); sif.bus_addr_ok = 0; sif.flush = 1;
    nxt(); sif.flush = 0; sif.inst_en = 0; sif.bus_data_ok = 1; sif.bus_rdata = 32'hDEADBEEF;
    nxt(); sif.bus_data_ok = 0;
    #1 chk("t5.c4.irdata", sif.inst_rdata, 32'h33334444); chk("t5.c4.bus_req", sif.bus_req, 0);
    nxt(); sif.inst_en = 1; sif.inst_addr = 32'hBFC00380;
    #1 chk("t5.c5.i_stall", sif.i_stall, 1);
    nxt(); sif.bus_addr_ok = 1;
    #1 chk("t5.c6.bus_req", sif.bus_req, 1); chk("t5.c6.addr", sif.bus_addr, 32'hBFC00380);
    nxt(); sif.bus_addr_ok = 0; sif.bus_data_ok = 1; sif.bus_rdata = 32'h24080000;
    nxt(); sif.bus_data_ok = 0;
    #1 chk("t5.c8.i_stall", sif.i_stall, 0); chk("t5.c8.irdata", sif.inst_rdata, 32'h24080000);
    nxt(); sif.inst_en = 0;

    // Reset while waiting, then a fresh fetch
    nxt(); sif.inst_en = 1; sif.inst_addr = 32'hBFC00010;
    nxt(); sif.bus_addr_ok = 1;
    nxt(); sif.bus_addr_ok = 0; rst = 0;
    #1 chk("t6.rst.bus_req", sif.bus_req, 0); chk("t6.rst.addr", sif.bus_addr, 0);
    chk("t6.rst.irdata", sif.inst_rdata, 0); chk("t6.rst.drdata", sif.data_rdata, 0);
    chk("t6.rst.wdata", sif.bus_wdata, 0);
    nxt(); rst = 1;
    #1 chk("t6.c0.i_stall", sif.i_stall, 1);
    nxt(); sif.bus_addr_ok = 1;
    #1 chk("t6.c1.bus_req", sif.bus_req, 1); chk("t6.c1.addr", sif.bus_addr, 32'hBFC00010);
    nxt(); sif.bus_addr_ok = 0; sif.bus_data_ok = 1; sif.bus_rdata = 32'h8C020000;
    nxt(); sif.bus_data_ok = 0;
    #1 chk("t6.c3.i_stall", sif.i_stall, 0); chk("t6.c3.irdata", sif.inst_rdata, 32'h8C020000);
    nxt(); sif.inst_en = 0;
    nxt(); nxt();

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
